// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types for the shadow trace pipeline
package trace_pkg;

  typedef struct packed {
    logic        v;
    logic        fresh;
    logic [31:0] id;
    logic [31:0] pc;
    logic [31:0] inst;
  } trace_stage_t;

  localparam int NSTAGE = 4;
  localparam int ST_I   = 0;
  localparam int ST_X   = 1;
  localparam int ST_M   = 2;
  localparam int ST_R   = 3;

  // Sequence ID of a stage occupant, 0 when the stage is empty.
  function automatic int stage_id(trace_stage_t s);
    return s.v ? int'(s.id) : 0;
  endfunction

  // A stage copied downstream is fresh exactly when it carries an instruction.
  function automatic trace_stage_t advance(trace_stage_t s);
    trace_stage_t r;
    r       = s;
    r.fresh = s.v;
    return r;
  endfunction

endpackage

// File: rtl/trace_tracker.sv
// rtl/trace_tracker.sv - assigns sequence IDs and mirrors the core I/X/M/R pipeline for tracing
module trace_tracker
  import trace_pkg::*;
#(
  parameter logic [31:0] ID_START = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_v,
  input  logic [31:0] issue_pc,
  input  logic [31:0] issue_inst,
  input  logic        stall,
  input  logic        flush,
  input  logic        x_rdv,
  input  logic [4:0]  x_rd,
  input  logic [31:0] x_rd_data,
  input  logic        x_pcv,
  input  logic [31:0] x_pc,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        rdv,
  output logic [4:0]  rd_x,
  output logic [31:0] rd_data,
  output logic        pcv,
  output logic [31:0] pc_x,
  output logic        inst_v_i,
  output logic        inst_v_x,
  output logic        inst_v_m,
  output logic        inst_v_r,
  output int          ci,
  output int          cx,
  output int          cm,
  output int          cr,
  output logic        kill_v,
  output int          ck
);

  trace_stage_t        st_q [NSTAGE];
  logic [31:0]         next_id;
  trace_stage_t        issue_entry;
  logic                load_i;
  logic                live;
  logic                x_v;
  logic [NSTAGE-1:0]   fresh_ev;

  assign load_i = issue_v & ~flush;

  always_comb begin
    issue_entry       = '0;
    issue_entry.v     = 1'b1;
    issue_entry.fresh = 1'b1;
    issue_entry.id    = next_id;
    issue_entry.pc    = issue_pc;
    issue_entry.inst  = issue_inst;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q[ST_I] <= '0;
      st_q[ST_X] <= '0;
      st_q[ST_M] <= '0;
      st_q[ST_R] <= '0;
      next_id    <= ID_START;
    end else if (stall) begin
      st_q[ST_I].fresh <= 1'b0;
      st_q[ST_X].fresh <= 1'b0;
      st_q[ST_M].fresh <= 1'b0;
      st_q[ST_R].fresh <= 1'b0;
    end else begin
      st_q[ST_R] <= advance(st_q[ST_M]);
      st_q[ST_M] <= advance(st_q[ST_X]);
      st_q[ST_X] <= flush ? '0 : advance(st_q[ST_I]);
      st_q[ST_I] <= load_i ? issue_entry : '0;
      // A dropped issue does not consume an ID; wrap is plain 32-bit rollover.
      if (load_i) next_id <= next_id + 32'd1;
    end
  end

  // Outputs are held at zero while reset is asserted, since the stage
  // registers only clear at the end of the reset cycle.
  assign live = ~reset;
  assign x_v  = live & st_q[ST_X].v;

  always_comb begin
    fresh_ev = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      fresh_ev[i] = live & ~stall & st_q[i].v & st_q[i].fresh;
    end
  end

  assign inst_v_i = fresh_ev[ST_I];
  assign inst_v_x = fresh_ev[ST_X];
  assign inst_v_m = fresh_ev[ST_M];
  assign inst_v_r = fresh_ev[ST_R];

  assign ci = live ? stage_id(st_q[ST_I]) : 0;
  assign cx = live ? stage_id(st_q[ST_X]) : 0;
  assign cm = live ? stage_id(st_q[ST_M]) : 0;
  assign cr = live ? stage_id(st_q[ST_R]) : 0;

  assign valid   = inst_v_x;
  assign pc      = x_v ? st_q[ST_X].pc   : 32'd0;
  assign inst    = x_v ? st_q[ST_X].inst : 32'd0;
  assign rdv     = x_v & ~stall & x_rdv;
  assign rd_x    = x_v ? x_rd      : 5'd0;
  assign rd_data = x_v ? x_rd_data : 32'd0;
  assign pcv     = x_v & ~stall & x_pcv;
  assign pc_x    = x_v ? x_pc : 32'd0;

  assign kill_v = live & flush & ~stall & st_q[ST_I].v;
  assign ck     = live ? stage_id(st_q[ST_I]) : 0;

  // The core must only report an X-stage write for a live, moving X occupant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!((x_rdv || x_pcv) && (!st_q[ST_X].v || stall)))
        else $error("trace_tracker: x-stage write/redirect without a valid unstalled X instruction");
    end
  end

endmodule

// File: tb/tb_trace_tracker.sv
// tb/tb_trace_tracker.sv - table-driven check of trace_tracker plus an ID-wrap sequence
module tb_trace_tracker;

  localparam logic [31:0] INST_TAG = 32'h0000_0013;
  localparam logic [4:0]  RD_CONST = 5'd9;
  localparam logic [31:0] RD_DATA  = 32'hCAFE_0009;

  logic        clk = 1'b0;
  logic        reset, issue_v, stall, flush, x_rdv, x_pcv;
  logic [31:0] issue_pc, issue_inst, x_pc, x_rd_data;
  logic [4:0]  x_rd;

  logic        valid, rdv, pcv, inst_v_i, inst_v_x, inst_v_m, inst_v_r, kill_v;
  logic [31:0] pc, inst, rd_data, pc_x;
  logic [4:0]  rd_x;
  int          ci, cx, cm, cr, ck;

  logic        valid_b, rdv_b, pcv_b, inst_v_i_b, inst_v_x_b, inst_v_m_b, inst_v_r_b, kill_v_b;
  logic [31:0] pc_b, inst_b, rd_data_b, pc_x_b;
  logic [4:0]  rd_x_b;
  int          ci_b, cx_b, cm_b, cr_b, ck_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trace_tracker #(.ID_START(32'd0)) dut (
    .clk(clk), .reset(reset), .issue_v(issue_v), .issue_pc(issue_pc), .issue_inst(issue_inst),
    .stall(stall), .flush(flush), .x_rdv(x_rdv), .x_rd(x_rd), .x_rd_data(x_rd_data),
    .x_pcv(x_pcv), .x_pc(x_pc), .valid(valid), .pc(pc), .inst(inst), .rdv(rdv), .rd_x(rd_x),
    .rd_data(rd_data), .pcv(pcv), .pc_x(pc_x), .inst_v_i(inst_v_i), .inst_v_x(inst_v_x),
    .inst_v_m(inst_v_m), .inst_v_r(inst_v_r), .ci(ci), .cx(cx), .cm(cm), .cr(cr),
    .kill_v(kill_v), .ck(ck)
  );

  trace_tracker #(.ID_START(32'hFFFF_FFFE)) dut_wrap (
    .clk(clk), .reset(reset), .issue_v(issue_v), .issue_pc(issue_pc), .issue_inst(issue_inst),
    .stall(stall), .flush(flush), .x_rdv(x_rdv), .x_rd(x_rd), .x_rd_data(x_rd_data),
    .x_pcv(x_pcv), .x_pc(x_pc), .valid(valid_b), .pc(pc_b), .inst(inst_b), .rdv(rdv_b),
    .rd_x(rd_x_b), .rd_data(rd_data_b), .pcv(pcv_b), .pc_x(pc_x_b), .inst_v_i(inst_v_i_b),
    .inst_v_x(inst_v_x_b), .inst_v_m(inst_v_m_b), .inst_v_r(inst_v_r_b), .ci(ci_b),
    .cx(cx_b), .cm(cm_b), .cr(cr_b), .kill_v(kill_v_b), .ck(ck_b)
  );

  typedef struct {
    bit          rst, iv;
    logic [31:0] ipc;
    bit          st, fl, xr, xp;
    logic [31:0] xpc;
    logic [3:0]  ev;      // {i, x, m, r}
    int          ci, cx, cm, cr;
    bit          kill;
    int          ck;
    logic [31:0] epc;
    bit          erdv, epcv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit iv, logic [31:0] ipc, bit st, bit fl, bit xr, bit xp,
                              logic [31:0] xpc, logic [3:0] ev, int eci, int ecx, int ecm, int ecr,
                              bit kill, int eck, logic [31:0] epc, bit erdv, bit epcv);
    vec_t t;
    t.rst = rst; t.iv = iv; t.ipc = ipc; t.st = st; t.fl = fl; t.xr = xr; t.xp = xp; t.xpc = xpc;
    t.ev = ev; t.ci = eci; t.cx = ecx; t.cm = ecm; t.cr = ecr; t.kill = kill; t.ck = eck;
    t.epc = epc; t.erdv = erdv; t.epcv = epcv;
    return t;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    reset      = t.rst;
    issue_v    = t.iv;
    issue_pc   = t.ipc;
    issue_inst = t.ipc ^ INST_TAG;
    stall      = t.st;
    flush      = t.fl;
    x_rdv      = t.xr;
    x_pcv      = t.xp;
    x_pc       = t.xpc;
    x_rd       = RD_CONST;
    x_rd_data  = RD_DATA;
  endtask

  task automatic check_row(input int n, input vec_t t);
    chk("events", n, 32'({inst_v_i, inst_v_x, inst_v_m, inst_v_r}), 32'(t.ev));
    chk("ci", n, ci, t.ci);
    chk("cx", n, cx, t.cx);
    chk("cm", n, cm, t.cm);
    chk("cr", n, cr, t.cr);
    chk("valid", n, 32'(valid), 32'(t.ev[2]));
    chk("kill_v", n, 32'(kill_v), 32'(t.kill));
    chk("rdv", n, 32'(rdv), 32'(t.erdv));
    chk("pcv", n, 32'(pcv), 32'(t.epcv));
    if (t.kill) chk("ck", n, ck, t.ck);
    if (t.ev[2]) begin
      chk("pc", n, pc, t.epc);
      chk("inst", n, inst, t.epc ^ INST_TAG);
    end
    if (t.erdv) begin
      chk("rd_x", n, 32'(rd_x), 32'(RD_CONST));
      chk("rd_data", n, rd_data, RD_DATA);
    end
    if (t.epcv) chk("pc_x", n, pc_x, t.xpc);
  endtask

  initial begin
    vec_t idle;
    int   e_ci[5];
    int   e_cx[5];
    int   e_cr[5];

    // reset, then three back-to-back issues draining through R
    tbl.push_back(mk(1,0,32'h00,0,0,0,0,32'h0,   4'b0000, 0,0,0,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(1,0,32'h00,0,0,0,0,32'h0,   4'b0000, 0,0,0,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,1,32'h00,0,0,0,0,32'h0,   4'b0000, 0,0,0,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,1,32'h04,0,0,0,0,32'h0,   4'b1000, 0,0,0,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,1,32'h08,0,0,1,0,32'h0,   4'b1100, 1,0,0,0, 0,0, 32'h00, 1,0));
    tbl.push_back(mk(0,0,32'h00,0,0,0,0,32'h0,   4'b1110, 2,1,0,0, 0,0, 32'h04, 0,0));
    tbl.push_back(mk(0,0,32'h00,0,0,0,0,32'h0,   4'b0111, 0,2,1,0, 0,0, 32'h08, 0,0));
    tbl.push_back(mk(0,0,32'h00,0,0,0,0,32'h0,   4'b0011, 0,0,2,1, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,0,32'h00,0,0,0,0,32'h0,   4'b0001, 0,0,0,2, 0,0, 32'h00, 0,0));
    // branch in X redirects while ID 5 sits in I; same-cycle issue is dropped
    tbl.push_back(mk(0,1,32'h40,0,0,0,0,32'h0,   4'b0000, 0,0,0,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,1,32'h44,0,0,0,0,32'h0,   4'b1000, 3,0,0,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,1,32'h48,0,0,0,0,32'h0,   4'b1100, 4,3,0,0, 0,0, 32'h40, 0,0));
    tbl.push_back(mk(0,1,32'h4C,0,1,0,1,32'h100, 4'b1110, 5,4,3,0, 1,5, 32'h44, 0,1));
    tbl.push_back(mk(0,1,32'h100,0,0,0,0,32'h0,  4'b0011, 0,0,4,3, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,0,32'h00,0,0,0,0,32'h0,   4'b1001, 6,0,0,4, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,0,32'h00,0,0,0,0,32'h0,   4'b0100, 0,6,0,0, 0,0, 32'h100, 0,0));
    tbl.push_back(mk(0,0,32'h00,0,0,0,0,32'h0,   4'b0010, 0,0,6,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,0,32'h00,0,1,0,0,32'h0,   4'b0001, 0,0,0,6, 0,0, 32'h00, 0,0));
    // two stall cycles: no events, IDs held, issue/flush ignored, no duplicate afterwards
    tbl.push_back(mk(0,1,32'h20,0,0,0,0,32'h0,   4'b0000, 0,0,0,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,1,32'h24,0,0,0,0,32'h0,   4'b1000, 7,0,0,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,1,32'h28,1,0,0,0,32'h0,   4'b0000, 8,7,0,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,0,32'h00,1,1,0,0,32'h0,   4'b0000, 8,7,0,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,0,32'h00,0,0,0,0,32'h0,   4'b0000, 8,7,0,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,0,32'h00,0,0,1,0,32'h0,   4'b0110, 0,8,7,0, 0,0, 32'h24, 1,0));
    tbl.push_back(mk(0,0,32'h00,0,0,0,0,32'h0,   4'b0011, 0,0,8,7, 0,0, 32'h00, 0,0));
    // fill all four stages, then reset mid-flight
    tbl.push_back(mk(0,1,32'h60,0,0,0,0,32'h0,   4'b0001, 0,0,0,8, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,1,32'h64,0,0,0,0,32'h0,   4'b1000, 9,0,0,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,1,32'h68,0,0,0,0,32'h0,   4'b1100, 10,9,0,0, 0,0, 32'h60, 0,0));
    tbl.push_back(mk(0,1,32'h6C,0,0,0,0,32'h0,   4'b1110, 11,10,9,0, 0,0, 32'h64, 0,0));
    tbl.push_back(mk(1,1,32'h70,0,0,0,0,32'h0,   4'b0000, 0,0,0,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,1,32'h80,0,0,0,0,32'h0,   4'b0000, 0,0,0,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,0,32'h00,0,0,0,0,32'h0,   4'b1000, 0,0,0,0, 0,0, 32'h00, 0,0));
    tbl.push_back(mk(0,0,32'h00,0,0,0,0,32'h0,   4'b0100, 0,0,0,0, 0,0, 32'h80, 0,0));

    idle = mk(0,0,32'h0,0,0,0,0,32'h0, 4'b0000, 0,0,0,0, 0,0, 32'h0, 0,0);
    drive(tbl[0]);
    @(posedge clk); #1;

    for (int n = 0; n < tbl.size(); n++) begin
      drive(tbl[n]);
      @(negedge clk);
      check_row(n, tbl[n]);
      @(posedge clk); #1;
    end

    // ID wrap on the second instance: -2, -1, 0
    e_ci = '{0, -2, -1, 0, 0};
    e_cx = '{0, 0, -2, -1, 0};
    e_cr = '{0, 0, 0, 0, -2};
    drive(idle);
    reset = 1'b1;
    @(negedge clk);
    chk("wrap_reset_ci", 100, ci_b, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      drive(idle);
      issue_v    = (k < 3);
      issue_pc   = 32'(4 * k);
      issue_inst = 32'(4 * k) ^ INST_TAG;
      @(negedge clk);
      chk("wrap_ci", 101 + k, ci_b, e_ci[k]);
      chk("wrap_cx", 101 + k, cx_b, e_cx[k]);
      chk("wrap_cr", 101 + k, cr_b, e_cr[k]);
      chk("wrap_inst_v_i", 101 + k, 32'(inst_v_i_b), 32'((k >= 1) && (k <= 3)));
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
